// File: rtl/gem_ext_fifo_tx_core.sv
// Bridges an 8-bit AXI-Stream frame source to the GEM external-FIFO TX port.
// Define GEM_EXT_FIFO_TX_STATUS_EN to expose the captured TX status (tx_status/tx_status_valid).
`timescale 1ns/1ps

module gem_ext_fifo_tx_core #(
    parameter int DATA_WIDTH   = 8,
    parameter int STATUS_WIDTH = 4,
    parameter int END_TIMEOUT  = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tid,
    input  logic                    s_axis_tdest,
    input  logic                    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   gem_data,
    output logic                    gem_data_ready,
    output logic                    gem_data_valid,
    input  logic                    gem_data_rd_request,
    output logic                    gem_sop,
    output logic                    gem_eop,
    output logic                    gem_err,
    output logic                    gem_underflow,
    output logic                    gem_control,
    output logic                    gem_dma_tx_status_tog,
    input  logic                    gem_dma_tx_end_tog,
    input  logic [STATUS_WIDTH-1:0] gem_status
`ifdef GEM_EXT_FIFO_TX_STATUS_EN
    ,
    output logic [STATUS_WIDTH-1:0] tx_status,
    output logic                    tx_status_valid
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SEND     = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_WAIT_END = 2'd3;

    localparam int              CNT_W    = (END_TIMEOUT > 1) ? $clog2(END_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (END_TIMEOUT > 0) ? CNT_W'(END_TIMEOUT - 1) : '0;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_err;
    logic                  r_underflow;
    logic                  r_status_tog;
    logic                  r_end_ref;

    logic w_pop_idle;
    logic w_pop_send;
    logic w_pop;
    logic w_underrun;
    logic w_end_seen;
    logic w_timeout;

    assign w_pop_idle = (r_state == S_IDLE) && gem_data_rd_request && s_axis_tvalid;
    assign w_pop_send = (r_state == S_SEND) && gem_data_rd_request && s_axis_tvalid;
    assign w_pop      = w_pop_idle || w_pop_send;
    assign w_underrun = (r_state == S_SEND) && gem_data_rd_request && !s_axis_tvalid;
    assign w_end_seen = (r_state == S_WAIT_END) && (gem_dma_tx_end_tog != r_end_ref);
    assign w_timeout  = (r_state == S_WAIT_END) && (END_TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // Handshake outputs are held low while reset is asserted, even though IDLE would follow tvalid.
    assign s_axis_tready  = !rst && (w_pop || (r_state == S_DRAIN));
    assign gem_data_ready = !rst && (((r_state == S_IDLE) && s_axis_tvalid) || (r_state == S_SEND));

    assign gem_data              = r_data;
    assign gem_data_valid        = r_valid;
    assign gem_sop               = r_sop;
    assign gem_eop               = r_eop;
    assign gem_err               = r_err;
    assign gem_underflow         = r_underflow;
    assign gem_control           = 1'b0;
    assign gem_dma_tx_status_tog = r_status_tog;

    // NOTE: the end-toggle reference simply tracks its input every cycle, so it needs no reset.
    always_ff @(posedge clk) begin
        r_end_ref <= gem_dma_tx_end_tog;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_err        <= 1'b0;
            r_underflow  <= 1'b0;
            r_status_tog <= 1'b0;
        end else begin
            r_valid     <= w_pop || w_underrun;
            r_sop       <= w_pop_idle;
            r_eop       <= w_pop && s_axis_tlast;
            r_err       <= w_pop && s_axis_tlast && s_axis_tuser;
            r_underflow <= w_underrun;
            if (w_pop) begin
                r_data <= s_axis_tdata;
            end else if (w_underrun) begin
                r_data <= '0;
            end
            r_cnt <= (r_state == S_WAIT_END) ? r_cnt + 1'b1 : '0;
            if (w_end_seen) begin
                r_status_tog <= ~r_status_tog;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop_idle) begin
                        r_state <= s_axis_tlast ? S_WAIT_END : S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_pop_send && s_axis_tlast) begin
                        r_state <= S_WAIT_END;
                    end else if (w_underrun) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= S_WAIT_END;
                    end
                end
                default: begin
                    if (w_end_seen || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef GEM_EXT_FIFO_TX_STATUS_EN
    logic [STATUS_WIDTH-1:0] r_tx_status;
    logic                    r_tx_status_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_status       <= '0;
            r_tx_status_valid <= 1'b0;
        end else begin
            r_tx_status_valid <= w_end_seen;
            if (w_end_seen) begin
                r_tx_status <= gem_status;
            end
        end
    end

    assign tx_status       = r_tx_status;
    assign tx_status_valid = r_tx_status_valid;

    logic w_unused;
    assign w_unused = ^{s_axis_tkeep, s_axis_tid, s_axis_tdest};
`else
    logic w_unused;
    assign w_unused = ^{s_axis_tkeep, s_axis_tid, s_axis_tdest, gem_status};
`endif

endmodule

// File: tb/tb_gem_ext_fifo_tx_core.sv
// Randomized bench for gem_ext_fifo_tx_core against a cycle-level behavioural model of the bridge.
`timescale 1ns/1ps

module tb_gem_ext_fifo_tx_core;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tkeep = 1'b0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tid = 1'b0;
    logic       s_axis_tdest = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic [7:0] gem_data;
    logic       gem_data_ready;
    logic       gem_data_valid;
    logic       gem_data_rd_request = 1'b0;
    logic       gem_sop;
    logic       gem_eop;
    logic       gem_err;
    logic       gem_underflow;
    logic       gem_control;
    logic       gem_dma_tx_status_tog;
    logic       gem_dma_tx_end_tog = 1'b0;
    logic [3:0] gem_status = '0;
`ifdef GEM_EXT_FIFO_TX_STATUS_EN
    logic [3:0] tx_status;
    logic       tx_status_valid;
`endif

    always #5 clk = ~clk;

    gem_ext_fifo_tx_core #(
        .DATA_WIDTH   (8),
        .STATUS_WIDTH (4),
        .END_TIMEOUT  (TMO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tkeep          (s_axis_tkeep),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tready         (s_axis_tready),
        .s_axis_tlast          (s_axis_tlast),
        .s_axis_tid            (s_axis_tid),
        .s_axis_tdest          (s_axis_tdest),
        .s_axis_tuser          (s_axis_tuser),
        .gem_data              (gem_data),
        .gem_data_ready        (gem_data_ready),
        .gem_data_valid        (gem_data_valid),
        .gem_data_rd_request   (gem_data_rd_request),
        .gem_sop               (gem_sop),
        .gem_eop               (gem_eop),
        .gem_err               (gem_err),
        .gem_underflow         (gem_underflow),
        .gem_control           (gem_control),
        .gem_dma_tx_status_tog (gem_dma_tx_status_tog),
        .gem_dma_tx_end_tog    (gem_dma_tx_end_tog),
        .gem_status            (gem_status)
`ifdef GEM_EXT_FIFO_TX_STATUS_EN
        ,
        .tx_status             (tx_status),
        .tx_status_valid       (tx_status_valid)
`endif
    );

    // Upstream store-and-forward FIFO contents; 'starve' withholds that byte for a few cycles.
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       starve;
    } byte_t;

    typedef enum int {M_IDLE, M_SEND, M_DRAIN, M_WAIT} mstate_t;

    byte_t   src_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;

    int      rd_mode = 0;       // 0: read strobe held high, 1: random strobes
    int      tog_mode = 0;      // 0: random end-toggle delay, 1: fixed delay, 2: never
    int      tog_fixed = 0;
    int      status_force = -1;
    int      hold = 0;
    int      tog_delay = -1;

    mstate_t    m_state = M_IDLE;
    int         m_wait_start = 0;
    logic       m_ref = 1'b0;
    logic [7:0] e_data = '0;
    logic       e_valid = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_err = 1'b0, e_uf = 1'b0;
    logic       e_stog = 1'b0, e_txsv = 1'b0;
    logic [3:0] e_txs = '0;

    int n_beats = 0, n_sops = 0, n_eops = 0, n_errs = 0, n_ufs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_frame(input int len, input logic user, input int starve_idx);
        for (int i = 0; i < len; i++) begin
            byte_t b;
            b.data   = 8'($urandom);
            b.last   = (i == len - 1);
            b.user   = (i == len - 1) ? user : 1'($urandom);
            b.starve = (i == starve_idx);
            src_q.push_back(b);
        end
    endtask

    task automatic clear_counts();
        n_beats = 0; n_sops = 0; n_eops = 0; n_errs = 0; n_ufs = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(gem_data_ready), 0);
        check({tag, "_tready"}, 32'(s_axis_tready), 0);
        check({tag, "_valid"}, 32'(gem_data_valid), 0);
        check({tag, "_data"}, 32'(gem_data), 0);
        check({tag, "_sop"}, 32'(gem_sop), 0);
        check({tag, "_eop"}, 32'(gem_eop), 0);
        check({tag, "_err"}, 32'(gem_err), 0);
        check({tag, "_uf"}, 32'(gem_underflow), 0);
        check({tag, "_ctrl"}, 32'(gem_control), 0);
        check({tag, "_stog"}, 32'(gem_dma_tx_status_tog), 0);
`ifdef GEM_EXT_FIFO_TX_STATUS_EN
        check({tag, "_txs"}, 32'(tx_status), 0);
        check({tag, "_txsv"}, 32'(tx_status_valid), 0);
`endif
    endtask

    // One clock cycle: entered just after a falling edge, left at the next falling edge.
    task automatic step();
        logic    pres, pop_ok, uf, end_seen, popped, e_tready, e_ready;
        mstate_t nstate;
        pres = 1'b0;
        if (hold > 0) begin
            hold--;
        end else if (src_q.size() > 0) begin
            if (src_q[0].starve) begin
                byte_t b = src_q[0];
                b.starve  = 1'b0;
                src_q[0]  = b;
                hold      = $urandom_range(2, 7);
            end else begin
                pres = 1'b1;
            end
        end
        s_axis_tvalid = pres;
        s_axis_tdata  = pres ? src_q[0].data : 8'($urandom);
        s_axis_tlast  = pres ? src_q[0].last : 1'($urandom);
        s_axis_tuser  = pres ? src_q[0].user : 1'($urandom);
        s_axis_tkeep  = 1'($urandom);
        s_axis_tid    = 1'($urandom);
        s_axis_tdest  = 1'($urandom);
        gem_data_rd_request = (rd_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
        if (tog_delay == 0) begin
            gem_dma_tx_end_tog = ~gem_dma_tx_end_tog;
            tog_delay = -1;
        end else if (tog_delay > 0) begin
            tog_delay--;
        end else if (tog_mode == 0 && m_state != M_WAIT && $urandom_range(0, 39) == 0) begin
            gem_dma_tx_end_tog = ~gem_dma_tx_end_tog;
        end
        gem_status = (status_force >= 0) ? 4'(status_force) : 4'($urandom);
        #1;

        pop_ok   = s_axis_tvalid && gem_data_rd_request && (m_state == M_IDLE || m_state == M_SEND);
        uf       = (m_state == M_SEND) && gem_data_rd_request && !s_axis_tvalid;
        e_tready = pop_ok || (m_state == M_DRAIN);
        e_ready  = ((m_state == M_IDLE) && s_axis_tvalid) || (m_state == M_SEND);
        check("tready", 32'(s_axis_tready), 32'(e_tready));
        check("data_ready", 32'(gem_data_ready), 32'(e_ready));
        check("control", 32'(gem_control), 0);

        e_valid = pop_ok || uf;
        e_sop   = pop_ok && (m_state == M_IDLE);
        e_eop   = pop_ok && s_axis_tlast;
        e_err   = pop_ok && s_axis_tlast && s_axis_tuser;
        e_uf    = uf;
        if (pop_ok) e_data = s_axis_tdata;
        else if (uf) e_data = '0;

        end_seen = (m_state == M_WAIT) && (gem_dma_tx_end_tog != m_ref);
        e_txsv   = end_seen;
        if (end_seen) begin
            e_stog = ~e_stog;
            e_txs  = gem_status;
        end

        nstate = m_state;
        case (m_state)
            M_IDLE:  if (pop_ok) nstate = s_axis_tlast ? M_WAIT : M_SEND;
            M_SEND:  if (pop_ok && s_axis_tlast) nstate = M_WAIT; else if (uf) nstate = M_DRAIN;
            M_DRAIN: if (s_axis_tvalid && s_axis_tlast) nstate = M_WAIT;
            default: if (end_seen || (cyc - m_wait_start + 1 == TMO)) nstate = M_IDLE;
        endcase
        popped = e_tready && s_axis_tvalid;

        @(posedge clk);
        m_ref = gem_dma_tx_end_tog;
        if (popped) void'(src_q.pop_front());
        cyc++;
        if (nstate == M_WAIT && m_state != M_WAIT) begin
            m_wait_start = cyc;
            tog_delay = (tog_mode == 0) ? $urandom_range(0, 24) : (tog_mode == 1) ? tog_fixed : -1;
        end
        m_state = nstate;

        @(negedge clk);
        check("valid", 32'(gem_data_valid), 32'(e_valid));
        check("sop", 32'(gem_sop), 32'(e_sop));
        check("eop", 32'(gem_eop), 32'(e_eop));
        check("err", 32'(gem_err), 32'(e_err));
        check("underflow", 32'(gem_underflow), 32'(e_uf));
        check("status_tog", 32'(gem_dma_tx_status_tog), 32'(e_stog));
        if (e_valid) check("data", 32'(gem_data), 32'(e_data));
`ifdef GEM_EXT_FIFO_TX_STATUS_EN
        check("tx_status", 32'(tx_status), 32'(e_txs));
        check("tx_status_valid", 32'(tx_status_valid), 32'(e_txsv));
`endif
        if (gem_data_valid) n_beats++;
        if (gem_data_valid && gem_sop) n_sops++;
        if (gem_data_valid && gem_eop) n_eops++;
        if (gem_data_valid && gem_err) n_errs++;
        if (gem_data_valid && gem_underflow) n_ufs++;
    endtask

    task automatic run_until_idle(input int budget);
        int used = 0;
        while (!(src_q.size() == 0 && m_state == M_IDLE) && used < budget) begin
            step();
            used++;
        end
        check("idle_budget", 32'(used < budget), 1);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_all_zero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero({tag, "_hold"});
        #1 rst = 1'b0;
        m_state = M_IDLE;
        m_ref   = gem_dma_tx_end_tog;
        e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_err = 1'b0; e_uf = 1'b0;
        e_stog  = 1'b0; e_txs = '0; e_txsv = 1'b0; e_data = '0;
        tog_delay = -1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic stog_before;
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check_all_zero("reset");
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        m_ref = gem_dma_tx_end_tog;

        // 64-byte frame, read strobe held, end toggle answered with status 4'hA
        rd_mode = 0; tog_mode = 1; tog_fixed = 3; status_force = 4'hA;
        clear_counts();
        push_frame(64, 1'b0, -1);
        run_until_idle(400);
        check("A_beats", 32'(n_beats), 64);
        check("A_sops", 32'(n_sops), 1);
        check("A_eops", 32'(n_eops), 1);
        check("A_errs", 32'(n_errs), 0);
        check("A_stog", 32'(gem_dma_tx_status_tog), 1);
`ifdef GEM_EXT_FIFO_TX_STATUS_EN
        check("A_txs", 32'(tx_status), 32'h A);
`endif

        // Bad frame flagged on tlast
        status_force = -1; tog_mode = 0;
        clear_counts();
        push_frame(20, 1'b1, -1);
        run_until_idle(400);
        check("B_errs", 32'(n_errs), 1);
        check("B_eops", 32'(n_eops), 1);

        // Source starves after byte 10 while the GEM keeps reading
        clear_counts();
        push_frame(30, 1'b0, 11);
        run_until_idle(400);
        check("C_ufs", 32'(n_ufs), 1);
        check("C_beats", 32'(n_beats), 12);
        check("C_eops", 32'(n_eops), 0);

        // No end toggle: timeout returns to IDLE without acknowledging, next frame still sent
        tog_mode = 2;
        stog_before = e_stog;
        push_frame(10, 1'b0, -1);
        run_until_idle(400);
        check("D_stog", 32'(gem_dma_tx_status_tog), 32'(stog_before));
        tog_mode = 0;
        clear_counts();
        push_frame(12, 1'b0, -1);
        run_until_idle(400);
        check("D_next_beats", 32'(n_beats), 12);

        // Reset in the middle of a frame; remaining bytes stay upstream
        push_frame(40, 1'b0, -1);
        repeat (25) step();
        do_reset("midrst");
        run_until_idle(400);

        // Randomized traffic
        for (int f = 0; f < 40; f++) begin
            int len;
            rd_mode  = $urandom_range(0, 1);
            tog_mode = ($urandom_range(0, 7) == 0) ? 2 : 0;
            for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                len = $urandom_range(1, 70);
                push_frame(len, 1'($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1);
            end
            run_until_idle(4000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
